// File: rtl/udc_pkg.sv
// udc_pkg -- shared types and next-value arithmetic for the bounded up/down
// counter (udc_bounded).
//
// Contents:
//   dir_e     : count direction (DIR_DOWN, DIR_UP)
//   mode_e    : bound behaviour (MODE_WRAP, MODE_SAT)
//   next_t    : result of one count step {value, ovf, unf}
//   udc_next  : next-value function used by the counter datapath
//
// The function works at UDC_MAX_W bits. Callers zero-extend narrower
// operands and take the low WIDTH bits of the result. The result always
// fits in WIDTH bits because it is a bound, the old count, or an in-range
// sum or difference.
package udc_pkg;

  localparam int unsigned UDC_MAX_W = 32;

  typedef enum logic {
    DIR_DOWN = 1'b0,
    DIR_UP   = 1'b1
  } dir_e;

  typedef enum logic {
    MODE_WRAP = 1'b0,
    MODE_SAT  = 1'b1
  } mode_e;

  typedef struct packed {
    logic [UDC_MAX_W-1:0] value;
    logic                 ovf;
    logic                 unf;
  } next_t;

  // One advance of the counter. Sums and bound tests are done one bit wider
  // than the operands, so that count+step or lo+step can never alias back
  // into range.
  function automatic next_t udc_next(
    input logic [UDC_MAX_W-1:0] count,
    input logic [UDC_MAX_W-1:0] step,
    input logic [UDC_MAX_W-1:0] lo,
    input logic [UDC_MAX_W-1:0] hi,
    input dir_e                 dir,
    input mode_e                mode
  );
    logic [UDC_MAX_W:0] sum;
    logic [UDC_MAX_W:0] floor_v;
    next_t              r;
    r.value = count;
    r.ovf   = 1'b0;
    r.unf   = 1'b0;
    sum     = {1'b0, count} + {1'b0, step};
    floor_v = {1'b0, lo} + {1'b0, step};
    // A zero step never moves the count and never signals an event. This
    // holds even when the count sits outside the current bounds.
    if (step != '0) begin
      if (dir == DIR_UP) begin
        if (sum <= {1'b0, hi}) begin
          r.value = sum[UDC_MAX_W-1:0];
        end else begin
          r.ovf   = 1'b1;
          r.value = (mode == MODE_SAT) ? hi : lo;
        end
      end else begin
        if ({1'b0, count} >= floor_v) begin
          r.value = count - step;
        end else begin
          r.unf   = 1'b1;
          r.value = (mode == MODE_SAT) ? lo : hi;
        end
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/udc_prescaler.sv
// udc_prescaler -- modulo-PRESCALE counter of enable cycles.
//
// Ports:
//   clk   : clock, rising edge
//   rst   : synchronous active-high reset
//   en    : enable cycle to be counted
//   clear : return the count to zero (load in the parent counter)
//   tick  : combinational; high on the en cycle that completes a period
//
// The count holds while en is low. When tick is high the count wraps to 0 on
// the same edge. With PRESCALE == 1, tick follows en.
module udc_prescaler #(
  parameter int unsigned PRESCALE = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clear,
  output logic tick
);

  localparam int unsigned PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

  logic [PW-1:0] cnt;

  assign tick = en && (cnt == LAST);

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      cnt <= '0;
    end else if (tick) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/udc_bounded.sv
// udc_bounded -- parametrised up/down counter with runtime step and bounds,
// wrap or saturate mode, range-checked load and registered event pulses.
//
// Parameters:
//   WIDTH    : counter / bound / step width (2..32)
//   PRESCALE : enable cycles per count step (used only with UDC_PRESCALE_EN)
//
// Ports:
//   clk, rst   : clock and synchronous active-high reset
//   en         : count enable
//   up_down    : 1 = up, 0 = down
//   sat_mode   : 1 = saturate at bounds, 0 = wrap to opposite bound
//   step       : step magnitude
//   lo_bound   : inclusive lower bound
//   hi_bound   : inclusive upper bound
//   load_en    : load request
//   load_value : value to load (clamped into [lo_bound, hi_bound])
//   count      : registered count
//   at_min     : count == lo_bound (combinational)
//   at_max     : count == hi_bound (combinational)
//   ovf, unf   : registered 1-cycle pulses, up/down step crossed a bound
//   load_err   : registered 1-cycle pulse, load value was clamped
//   cfg_err    : combinational, lo_bound > hi_bound; freezes the counter
//
// Build option: define UDC_PRESCALE_EN to insert udc_prescaler. With the
// prescaler, only every PRESCALE-th en cycle advances the count. Without it,
// every en cycle advances the count and PRESCALE is not used.
//
// Cycle priority: rst > cfg_err > load_en > advance > hold.
module udc_bounded
  import udc_pkg::*;
#(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned PRESCALE = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up_down,
  input  logic             sat_mode,
  input  logic [WIDTH-1:0] step,
  input  logic [WIDTH-1:0] lo_bound,
  input  logic [WIDTH-1:0] hi_bound,
  input  logic             load_en,
  input  logic [WIDTH-1:0] load_value,
  output logic [WIDTH-1:0] count,
  output logic             at_min,
  output logic             at_max,
  output logic             ovf,
  output logic             unf,
  output logic             load_err,
  output logic             cfg_err
);

  if (WIDTH < 2 || WIDTH > UDC_MAX_W || PRESCALE < 1) begin : g_bad_param
    $error("udc_bounded: WIDTH must be 2..32 and PRESCALE >= 1");
  end

  logic             advance;
  logic [WIDTH-1:0] load_clamped;
  logic             load_oor;
  next_t            nxt;
  logic             unused_nxt_hi;

  assign cfg_err = (lo_bound > hi_bound);
  assign at_min  = (count == lo_bound);
  assign at_max  = (count == hi_bound);

`ifdef UDC_PRESCALE_EN
  // Load and cfg_err take priority over counting. The prescaler must not
  // see those cycles as enable cycles. Under cfg_err it holds its count.
  udc_prescaler #(
    .PRESCALE (PRESCALE)
  ) u_prescaler (
    .clk   (clk),
    .rst   (rst),
    .en    (en && !cfg_err && !load_en),
    .clear (load_en && !cfg_err),
    .tick  (advance)
  );
`else
  assign advance = en;
`endif

  assign nxt = udc_next(UDC_MAX_W'(count), UDC_MAX_W'(step),
                        UDC_MAX_W'(lo_bound), UDC_MAX_W'(hi_bound),
                        dir_e'(up_down), mode_e'(sat_mode));

  // The upper bits of nxt.value are always zero, because every operand is
  // narrower.
  assign unused_nxt_hi = ^nxt.value;

  // NOTE: every output of a combinational block gets a default on entry.
  // Otherwise a path that does not assign it infers a latch.
  always_comb begin
    load_clamped = load_value;
    load_oor     = 1'b0;
    if (load_value < lo_bound) begin
      load_clamped = lo_bound;
      load_oor     = 1'b1;
    end else if (load_value > hi_bound) begin
      load_clamped = hi_bound;
      load_oor     = 1'b1;
    end
  end

  // NOTE: state registers use non-blocking assignments. Every flop then
  // samples pre-edge values, whatever order the statements are in.
  always_ff @(posedge clk) begin
    if (rst) begin
      count    <= '0;
      ovf      <= 1'b0;
      unf      <= 1'b0;
      load_err <= 1'b0;
    end else begin
      // Pulses default low and are re-asserted only by the event they mark.
      ovf      <= 1'b0;
      unf      <= 1'b0;
      load_err <= 1'b0;
      if (cfg_err) begin
        count <= count;
      end else if (load_en) begin
        count    <= load_clamped;
        load_err <= load_oor;
      end else if (advance) begin
        count <= nxt.value[WIDTH-1:0];
        ovf   <= nxt.ovf;
        unf   <= nxt.unf;
      end
    end
  end

endmodule

// File: doc/udc_bounded.md
# udc_bounded

Parametrised up/down counter, successor to the team's fixed 4-bit up/down counter. Adds configurable width, runtime step size, runtime lower/upper bounds, wrap or saturate mode, count enable, range-checked load, and registered overflow/underflow event pulses. Used as a general event/position counter in datapath control logic; optional prescaler divides the enable rate.

## Interface
- WIDTH, 8, counter/bound/step width (≥2)
- PRESCALE, 4, enables per count step when prescaler compiled in (≥1)
- clk  in  1  clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- en  in  1  count enable
- up_down  in  1  1 = count up, 0 = count down
- sat_mode  in  1  1 = saturate at bounds, 0 = wrap to opposite bound
- step  in  WIDTH  increment/decrement magnitude
- lo_bound  in  WIDTH  inclusive lower bound (unsigned)
- hi_bound  in  WIDTH  inclusive upper bound (unsigned)
- load_en  in  1  load request
- load_value  in  WIDTH  value to load
- count  out  WIDTH  registered counter value
- at_min  out  1  count == lo_bound (combinational from count)
- at_max  out  1  count == hi_bound (combinational from count)
- ovf  out  1  registered 1-cycle pulse: up step crossed hi_bound
- unf  out  1  registered 1-cycle pulse: down step crossed lo_bound
- load_err  out  1  registered 1-cycle pulse: load_value out of range, clamped
- cfg_err  out  1  combinational level: lo_bound > hi_bound

## Operation
- Priority per cycle: rst > cfg_err > load_en > en (advance) > hold.
- rst: count=0, ovf=unf=load_err=0, prescaler count=0.
- cfg_err=1: count, prescaler hold; ovf/unf/load_err=0; load ignored.
- Load: count <= clamp(load_value, lo_bound, hi_bound); load_err=1 iff clamped. Clears prescaler.
- Advance (en=1, step advance qualified): arithmetic in WIDTH+1 bits, unsigned, no truncation before compare.
  - Up: s = count + step. s ≤ hi_bound → count <= s. Else ovf=1; wrap: count <= lo_bound; saturate: count <= hi_bound.
  - Down: if count ≥ lo_bound + step (WIDTH+1 compare) → count <= count − step. Else unf=1; wrap: count <= hi_bound; saturate: count <= lo_bound.
- step=0: count holds, no ovf/unf.
- Saturated at hi_bound with further up step: count holds, ovf pulses each advancing cycle.
- count below lo_bound or above hi_bound (after bounds change at runtime, or out of reset with lo_bound>0): next advance applies same rules; up from below lo is legal arithmetic; down from above hi is legal arithmetic. No silent correction without load.
- sat_mode, step, bounds sampled at the advancing edge; changes take effect next cycle.

## Timing
- count, ovf, unf, load_err update 1 clock after qualifying input edge; pulses aligned with the count update they describe, deassert next cycle unless re-triggered.
- at_min/at_max/cfg_err: zero-latency combinational from registers/inputs.
- rst mid-anything wins same edge; no pending state survives.
- load_en and en same cycle: load only, prescaler cleared, no ovf/unf.

## Configuration
- UDC_PRESCALE_EN defined: internal modulo-PRESCALE counter of en cycles; count advances only on the en cycle where prescaler == PRESCALE−1, prescaler then returns to 0. Prescaler holds when en=0, clears on rst/load. PRESCALE=1 equals non-prescaled behaviour.
- Not defined: every en cycle advances; PRESCALE parameter ignored; no prescaler flops.

## Structure
- Package udc_pkg: enum typedef for direction (DIR_DOWN, DIR_UP) and mode (MODE_WRAP, MODE_SAT); next-value result struct {value, ovf, unf}.
- One sub-module: udc_prescaler (en, clear → tick), instantiated only under UDC_PRESCALE_EN.
- Next-value computation as a package function shared by RTL and scoreboard.

## Test plan
- rst with WIDTH=8, lo=0, hi=255: count=0, all pulses 0; then 3 up steps of step=1 → count 1,2,3 on successive edges.
- lo=10, hi=20, wrap, load 18, up step=3 → count=10, ovf=1 one cycle; down step=5 from 12 → count=20, unf=1.
- Same bounds, saturate: load 19, up step=4 → count=20, ovf=1; repeat → count stays 20, ovf=1 again.
- load_value=25 with hi=20 → count=20, load_err=1; load 5 with lo=10 → count=10, load_err=1; load_en with en same cycle → no ovf/unf.
- lo=30, hi=20 → cfg_err=1, count holds across en and load_en; rst asserted mid-sequence → count=0 next edge.
- UDC_PRESCALE_EN, PRESCALE=4, step=1: 8 consecutive en cycles → count advances by 2 (cycles 4, 8); en gap holds prescaler; load clears it.
